// File: rtl/s27_bist_ctrl.sv
// -----------------------------------------------------------------------------
// s27_bist_ctrl
//
// Built-in self-test sequencer for the s27 sequential benchmark core.
// A test is requested with START while idle. The block then:
//   1. FLUSH: drives the core inputs to 4'b0000 for FLUSH cycles so the core's
//      state elements settle to a known value.
//   2. RUN:   drives the core inputs from a 4-bit LFSR for NPAT cycles and
//      compacts the core output PO into a 16-bit serial signature register.
//   3. DONE:  pulses DONE for one cycle with PASS = (SIG == GOLDEN).
//
// Parameters
//   NPAT    RUN-phase pattern count, 1..65535
//   FLUSH   FLUSH-phase cycle count, 1..255
//   SEED    initial LFSR value (4'b0000 is replaced by 4'b0001)
//   GOLDEN  expected final signature
//
// Ports
//   CK      in   clock, rising edge
//   RN      in   asynchronous active-low reset
//   START   in   test request, sampled in IDLE only
//   ABORT   in   cancel a running test (only with S27_BIST_ABORT_EN)
//   PO      in   core output G17, sampled at each RUN-cycle edge
//   PI      out  core inputs {G3,G2,G1,G0}, registered
//   BUSY    out  high in FLUSH and RUN
//   DONE    out  one-cycle pulse at test completion
//   PASS    out  result of the last completed test
//   SIG     out  signature register
//
// Build option
//   S27_BIST_ABORT_EN  when defined, ABORT in FLUSH or RUN returns the block
//                      to IDLE at the next edge with no DONE pulse and
//                      PASS=0. When undefined, ABORT is ignored.
// -----------------------------------------------------------------------------
module s27_bist_ctrl #(
  parameter int unsigned  NPAT   = 64,
  parameter int unsigned  FLUSH  = 4,
  parameter logic [3:0]   SEED   = 4'b1001,
  parameter logic [15:0]  GOLDEN = 16'h0000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        ABORT,
  input  logic        PO,
  output logic [3:0]  PI,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 4'b0001.
  localparam logic [3:0]  SEED_EFF   = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH - 1);
  localparam logic [15:0] NPAT_LOAD  = 16'(NPAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [3:0]  lfsr_q,  lfsr_d;
  logic [15:0] sig_q,   sig_d;
  logic        pass_q,  pass_d;
  logic [3:0]  pi_q,    pi_d;

  // ---------------------------------------------------------------------------
  // Abort request, qualified by the build option.
  // ---------------------------------------------------------------------------
  logic abort_req;

`ifdef S27_BIST_ABORT_EN
  assign abort_req = ABORT;
`else
  logic unused_abort;
  assign unused_abort = ABORT;
  assign abort_req    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next values of the LFSR and of the signature register for one RUN edge.
  // ---------------------------------------------------------------------------
  logic [3:0]  lfsr_step;
  logic [15:0] sig_step;

  assign lfsr_step = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign sig_step  = {sig_q[14:0],
                      sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ PO};

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    pi_d    = 4'b0000;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          sig_d   = 16'h0000;
          pass_d  = 1'b0;
          lfsr_d  = SEED_EFF;
          cnt_d   = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (abort_req) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == 16'd0) begin
          // Present the first pattern together with the move into RUN so the
          // core sees it during the first RUN cycle.
          cnt_d   = NPAT_LOAD;
          pi_d    = lfsr_q;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          // The partial signature is kept for inspection.
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          sig_d  = sig_step;
          lfsr_d = lfsr_step;
          if (cnt_q == 16'd0) begin
            // PASS is resolved on the last RUN edge so it is already valid
            // during the DONE cycle.
            pass_d  = (sig_step == GOLDEN);
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 16'd1;
            pi_d  = lfsr_step;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK or negedge RN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      lfsr_q  <= SEED_EFF;
      sig_q   <= 16'h0000;
      pass_q  <= 1'b0;
      pi_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      pi_q    <= pi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. BUSY and DONE decode disjoint states, so they are never high
  // together.
  // ---------------------------------------------------------------------------
  assign PI   = pi_q;
  assign SIG  = sig_q;
  assign PASS = pass_q;
  assign BUSY = (state_q == ST_FLUSH) || (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s27_bist_ctrl
//
// Directed bench for s27_bist_ctrl. Three instances share the clock and reset:
//   dut_a  NPAT=4,  FLUSH=2, SEED=1001, GOLDEN=0000
//   dut_b  NPAT=4,  FLUSH=2, SEED=1001, GOLDEN=000F (shares dut_a stimulus)
//   dut_c  NPAT=15, FLUSH=1, SEED=0000, GOLDEN=0000 (own START/PO)
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_s27_bist_ctrl;

  logic        CK;
  logic        RN;
  logic        start, abort, po;
  logic        start_c, po_c;

  logic [3:0]  pi_a, pi_b, pi_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;

  int checks;
  int failures;

  s27_bist_ctrl #(.NPAT(4), .FLUSH(2), .SEED(4'b1001), .GOLDEN(16'h0000)) dut_a (
    .CK(CK), .RN(RN), .START(start), .ABORT(abort), .PO(po),
    .PI(pi_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a));

  s27_bist_ctrl #(.NPAT(4), .FLUSH(2), .SEED(4'b1001), .GOLDEN(16'h000F)) dut_b (
    .CK(CK), .RN(RN), .START(start), .ABORT(abort), .PO(po),
    .PI(pi_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b));

  s27_bist_ctrl #(.NPAT(15), .FLUSH(1), .SEED(4'b0000), .GOLDEN(16'h0000)) dut_c (
    .CK(CK), .RN(RN), .START(start_c), .ABORT(1'b0), .PO(po_c),
    .PI(pi_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .SIG(sig_c));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    logic [3:0]  pat_a  [4];
    logic [15:0] sig_p1 [4];
    logic [3:0]  pat_c  [15];
    logic [15:0] seen;
    logic        done_seen;

    pat_a  = '{4'b1001, 4'b0011, 4'b0110, 4'b1101};
    sig_p1 = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
    pat_c  = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    checks   = 0;
    failures = 0;
    RN = 1'b0; start = 1'b0; abort = 1'b0; po = 1'b0;
    start_c = 1'b0; po_c = 1'b0;

    // ---- Reset state ----
    #2;
    check("rst_pi",   {12'd0, pi_a},   16'h0000);
    check("rst_busy", {15'd0, busy_a}, 16'h0000);
    check("rst_done", {15'd0, done_a}, 16'h0000);
    check("rst_pass", {15'd0, pass_a}, 16'h0000);
    check("rst_sig",  sig_a,           16'h0000);
    check("rst_busy_c", {15'd0, busy_c}, 16'h0000);
    tick();
    RN = 1'b1;
    tick();

    // ---- Test 1: PO=0, expect SIG=0 and PASS=1 on dut_a ----
    start = 1'b1;
    tick();                      // t0
    start = 1'b0;
    check("t1_busy_t0", {15'd0, busy_a}, 16'h0001);
    check("t1_pi_t0",   {12'd0, pi_a},   16'h0000);
    tick();                      // t0+1
    check("t1_pi_flush", {12'd0, pi_a}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();                    // t0+2 .. t0+5
      check($sformatf("t1_pi_run%0d", i), {12'd0, pi_a}, {12'd0, pat_a[i]});
      check($sformatf("t1_done_run%0d", i), {15'd0, done_a}, 16'h0000);
    end
    tick();                      // t0+6
    check("t1_done",   {15'd0, done_a}, 16'h0001);
    check("t1_busy",   {15'd0, busy_a}, 16'h0000);
    check("t1_sig",    sig_a,           16'h0000);
    check("t1_pass",   {15'd0, pass_a}, 16'h0001);
    check("t1_pass_b", {15'd0, pass_b}, 16'h0000);
    check("t1_pi_done", {12'd0, pi_a},  16'h0000);
    tick();
    check("t1_done_off", {15'd0, done_a}, 16'h0000);
    check("t1_pass_hold", {15'd0, pass_a}, 16'h0001);

    // ---- Test 2: PO=1, signature steps 1,3,7,F ----
    po = 1'b1;
    start = 1'b1;
    tick();                      // t0
    start = 1'b0;
    check("t2_pass_clr", {15'd0, pass_a}, 16'h0000);
    check("t2_sig_clr",  sig_a,           16'h0000);
    tick();                      // t0+1
    for (int i = 0; i < 4; i++) begin
      tick();                    // t0+2 .. t0+5
      check($sformatf("t2_sig%0d", i), sig_a, sig_p1[i]);
      check($sformatf("t2_pi_b%0d", i), {12'd0, pi_b}, {12'd0, pat_a[i]});
    end
    tick();                      // t0+6
    check("t2_done",   {15'd0, done_a}, 16'h0001);
    check("t2_sig",    sig_a,           16'h000F);
    check("t2_pass_a", {15'd0, pass_a}, 16'h0000);
    check("t2_pass_b", {15'd0, pass_b}, 16'h0001);
    check("t2_sig_b",  sig_b,           16'h000F);
    check("t2_done_b", {15'd0, done_b}, 16'h0001);
    tick();
    check("t2_sig_hold", sig_a, 16'h000F);
    po = 1'b0;

    // ---- Test 3: START held high through the test ----
    start = 1'b1;
    tick();                      // t0
    for (int i = 1; i <= 5; i++) begin
      tick();                    // t0+1 .. t0+5
      check($sformatf("t3_nodone%0d", i), {15'd0, done_a}, 16'h0000);
    end
    check("t3_busy_t5", {15'd0, busy_a}, 16'h0001);
    tick();                      // t0+6
    check("t3_done",      {15'd0, done_a}, 16'h0001);
    check("t3_busy_done", {15'd0, busy_a}, 16'h0000);
    tick();                      // t0+7, IDLE
    check("t3_idle_busy", {15'd0, busy_a}, 16'h0000);
    check("t3_idle_done", {15'd0, done_a}, 16'h0000);
    tick();                      // t0+8, retriggered
    start = 1'b0;
    check("t3_retrig", {15'd0, busy_a}, 16'h0001);
    for (int i = 1; i <= 5; i++) tick();
    check("t3b_nodone", {15'd0, done_a}, 16'h0000);
    tick();
    check("t3b_done", {15'd0, done_a}, 16'h0001);
    check("t3b_pass", {15'd0, pass_a}, 16'h0001);
    tick();

    // ---- Test 4: ABORT during the 2nd RUN cycle, PO=1 ----
    po = 1'b1;
    start = 1'b1;
    tick();                      // t0
    start = 1'b0;
    tick();                      // t0+1
    tick();                      // t0+2, RUN cycle 1
    tick();                      // t0+3, RUN cycle 2
    check("t4_pi_run2", {12'd0, pi_a}, 16'h0003);
    abort = 1'b1;
    tick();                      // t0+4
    abort = 1'b0;
`ifdef S27_BIST_ABORT_EN
    check("t4_busy", {15'd0, busy_a}, 16'h0000);
    check("t4_pi",   {12'd0, pi_a},   16'h0000);
    check("t4_pass", {15'd0, pass_a}, 16'h0000);
    check("t4_sig",  sig_a,           16'h0001);
    done_seen = done_a;
    for (int i = 0; i < 4; i++) begin
      tick();
      done_seen = done_seen | done_a;
    end
    check("t4_nodone", {15'd0, done_seen}, 16'h0000);
`else
    check("t4_busy", {15'd0, busy_a}, 16'h0001);
    check("t4_pi",   {12'd0, pi_a},   16'h0006);
    check("t4_sig",  sig_a,           16'h0003);
    tick();                      // t0+5
    tick();                      // t0+6
    check("t4_done", {15'd0, done_a}, 16'h0001);
    check("t4_sig_f", sig_a,          16'h000F);
    check("t4_pass", {15'd0, pass_a}, 16'h0000);
    tick();
`endif
    po = 1'b0;

    // ---- Test 5: reset mid-RUN ----
    start = 1'b1;
    tick();                      // t0
    start = 1'b0;
    tick();
    tick();
    tick();                      // t0+3, RUN
    check("t5_busy_pre", {15'd0, busy_a}, 16'h0001);
    RN = 1'b0;
    #1;
    check("t5_pi",   {12'd0, pi_a},   16'h0000);
    check("t5_busy", {15'd0, busy_a}, 16'h0000);
    check("t5_sig",  sig_a,           16'h0000);
    check("t5_pass", {15'd0, pass_a}, 16'h0000);
    tick();
    RN = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seen = done_seen | done_a;
    end
    check("t5_nodone", {15'd0, done_seen}, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    check("t5_done", {15'd0, done_a}, 16'h0001);
    check("t5_pass_after", {15'd0, pass_a}, 16'h0001);
    tick();

    // ---- Test 6: SEED=0000, NPAT=15 on dut_c ----
    start_c = 1'b1;
    tick();                      // t0, FLUSH
    start_c = 1'b0;
    check("t6_busy_flush", {15'd0, busy_c}, 16'h0001);
    check("t6_pi_flush",   {12'd0, pi_c},   16'h0000);
    tick();                      // t0+1, first RUN pattern
    check("t6_first", {12'd0, pi_c}, 16'h0001);
    seen = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t6_pat%0d", i), {12'd0, pi_c}, {12'd0, pat_c[i]});
      seen[pi_c] = 1'b1;
      if (i < 14) tick();
    end
    check("t6_seen", seen, 16'hFFFE);
    tick();                      // t0+16
    check("t6_done", {15'd0, done_c}, 16'h0001);
    check("t6_busy", {15'd0, busy_c}, 16'h0000);
    check("t6_sig",  sig_c,           16'h0000);
    check("t6_pass", {15'd0, pass_c}, 16'h0001);
    tick();
    check("t6_done_off", {15'd0, done_c}, 16'h0000);
    check("t6_busy_b",   {15'd0, busy_b}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
